gsim_result_reorder: RTL and testbench
======================================

// Module: gsim_result_reorder
// PURPOSE
//   Downstream consumer of the GSIM solver. Captures the 16-word Q16.16 solution burst
//   (arrives in column-interleaved order x0,x4,x8,x12,x1,...,x15), reorders it into natural
//   index order x0..x15 and re-emits it on a valid/ready stream.
//   Also emits a rounded, saturated 16-bit integer view of each word for the result checker/host.
// PARAMETERS
//   DW      32  solution word width (Q16.16, signed); fixed to GSIM output width
//   NWORDS  16  words per solution frame; 4x4 interleave is hard-wired, only 16 is legal
//   FRAC    16  fractional bits used for integer rounding
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   x_valid    in   1   GSIM out_valid; high for 16 consecutive cycles per frame
//   x_in       in   32  GSIM x_out, signed Q16.16
//   m_valid    out  1   output word valid
//   m_ready    in   1   downstream ready; transfer when m_valid && m_ready
//   m_data     out  32  solution word x[m_idx], Q16.16
//   m_idx      out  4   natural solution index 0..15
//   m_int      out  16  round(m_data), saturated to int16
//   m_last     out  1   high with m_idx==15
//   busy       out  1   high in COLLECT or DRAIN
//   frame_err  out  1   1-cycle pulse: burst shorter than 16 words
//   overrun    out  1   sticky: x_valid seen during DRAIN; cleared on next good COLLECT start
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; word counter 0; buffer contents don't-care (never emitted).
//   States: IDLE -> COLLECT -> DRAIN -> IDLE.
//   IDLE: x_valid=1 -> store word k=0 and go to COLLECT; cnt=1; overrun cleared that cycle.
//   COLLECT: each x_valid cycle stores word k=cnt at buf[{k[1:0],k[3:2]}], cnt++.
//     Word k=15 stored -> DRAIN; cnt=0.
//     x_valid=0 before k=15 -> frame_err pulses next cycle; go to IDLE; partial frame discarded.
//   DRAIN: m_valid=1 from cycle after 16th word captured (latency 1 clk).
//     m_idx = rd pointer 0..15; m_data = buf[rd]; m_last = (rd==15).
//     Stall (m_ready=0): m_valid, m_data, m_idx, m_int, m_last held stable.
//     Transfer: rd++; transfer with rd==15 -> m_valid=0, IDLE next cycle (no bubble required between words).
//     x_valid=1 in DRAIN: word dropped, overrun set; drain unaffected.
//   IDLE with x_valid=1 on same cycle DRAIN exits: treated as new frame start (IDLE entered first, so
//     a word arriving on the final-transfer cycle is dropped and sets overrun).
//   m_int: t = m_data + 2^(FRAC-1) (33-bit signed add, no wrap); q = t >>> FRAC;
//     q > 32767 -> 32767; q < -32768 -> -32768; else q[15:0]. Round-half-up (toward +inf).
//   m_int/m_data/m_idx/m_last registered; all change only on transfer or state entry.
//   busy = (state != IDLE). frame_err and overrun are registered.
//   Reset asserted mid-frame or mid-drain: immediate return to IDLE, m_valid=0, no partial output.
// TESTING
//   1 Burst x_in = k*65536 (k=0..15 arrival), m_ready=1 -> m_idx 0..15 carry
//     m_data = ({idx[1:0],idx[3:2]})*65536 order: idx0=0, idx1=4*65536, idx4=1*65536;
//     m_last at idx15; first m_valid 1 clk after 16th word; busy drops after last.
//   2 m_ready toggled 1,0,0,1,... during drain -> every word delivered once,
//     outputs stable while stalled, exactly 16 transfers.
//   3 Rounding: 0x00018000 -> m_int 2; 0xFFFF8000 -> 0; 0xFFFE7FFF -> -2;
//     0x7FFFFFFF -> 32767; 0x80000000 -> -32768.
//   4 x_valid drops after 9 words -> frame_err single pulse, no m_valid,
//     next full burst processed correctly.
//   5 New x_valid burst while m_ready=0 in DRAIN -> overrun=1, drained data = first frame;
//     overrun clears at next frame start in IDLE.
//   6 reset pulsed at drain word 7 -> m_valid=0 immediately, busy=0;
//     next burst yields clean 16-word frame starting idx 0.

Source files
------------

// File: rtl/gsim_result_reorder.sv
// Captures a column-interleaved 16-word GSIM solution burst, reorders it into natural
// index order and replays it on a valid/ready stream with a rounded int16 view per word.
module gsim_result_reorder #(
    parameter int unsigned DW     = 32,
    parameter int unsigned NWORDS = 16,
    parameter int unsigned FRAC   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [31:0]   x_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic [3:0]    m_idx,
    output logic [15:0]   m_int,
    output logic          m_last,
    output logic          busy,
    output logic          frame_err,
    output logic          overrun
);

    localparam int unsigned IW   = $clog2(NWORDS);
    localparam int unsigned QW   = DW - FRAC + 1;
    localparam int unsigned HALF = 1 << (FRAC - 1);
    localparam logic signed [QW-1:0] QMAX = QW'(32767);
    localparam logic signed [QW-1:0] QMIN = QW'(-32768);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic [IW-1:0]   m_idx_q, m_idx_d;
    logic [15:0]     m_int_q, m_int_d;
    logic            m_last_q, m_last_d;
    logic            busy_q;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic [IW-1:0]   rd_nxt;
    logic [DW-1:0]   mem_q [NWORDS];

    // Round half toward +inf, then saturate into int16.
    function automatic logic [15:0] round_sat(input logic [DW-1:0] d);
        logic signed [DW:0]   t;
        logic signed [QW-1:0] q;
        t = $signed({d[DW-1], d}) + $signed((DW+1)'(HALF));
        q = t[DW:FRAC];
        if (q > QMAX) begin
            return 16'h7FFF;
        end else if (q < QMIN) begin
            return 16'h8000;
        end
        return q[15:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_idx_d     = m_idx_q;
        m_last_d    = m_last_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        wr_en       = 1'b0;
        // Arrival k lands at natural index {k[1:0],k[3:2]}.
        wr_addr     = {cnt_q[1:0], cnt_q[3:2]};
        rd_nxt      = m_idx_q + IW'(1);

        unique case (state_q)
            IDLE: begin
                if (x_valid) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    cnt_d     = IW'(1);
                    overrun_d = 1'b0;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (x_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == IW'(NWORDS - 1)) begin
                        state_d   = DRAIN;
                        cnt_d     = '0;
                        m_valid_d = 1'b1;
                        m_idx_d   = '0;
                        m_last_d  = 1'b0;
                        m_data_d  = mem_q[0];
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end else begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (x_valid) begin
                    overrun_d = 1'b1;
                end
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        m_idx_d  = rd_nxt;
                        m_last_d = (rd_nxt == IW'(NWORDS - 1));
                        m_data_d = mem_q[rd_nxt];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        m_int_d = round_sat(m_data_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_idx_q     <= '0;
            m_int_q     <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_idx_q     <= m_idx_d;
            m_int_q     <= m_int_d;
            m_last_q    <= m_last_d;
            busy_q      <= (state_d != IDLE);
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame buffer holds no state worth resetting; it is never read before being filled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= x_in;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_idx     = m_idx_q;
    assign m_int     = m_int_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_gsim_result_reorder.sv
// Directed/randomized bench for gsim_result_reorder with a behavioural reorder/rounding model.
module tb_gsim_result_reorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_idx;
    logic [15:0] m_int;
    logic        m_last;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] frame_w [16];
    logic [15:0] cap_int [16];

    gsim_result_reorder dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_int     (m_int),
        .m_last    (m_last),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arrival order is x0,x4,x8,x12,x1,... so natural x[n] arrived at position (n%4)*4 + n/4.
    function automatic logic [31:0] exp_word(input int n);
        return frame_w[(n % 4) * 4 + n / 4];
    endfunction

    function automatic logic [15:0] exp_round(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        v = (v + 32768) >>> 16;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 16; k++) frame_w[k] = $urandom;
    endtask

    task automatic send_frame(input int nwords);
        for (int k = 0; k < nwords; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("start_overrun_clear", 32'(overrun), 32'(0));
                chk("collect_busy", 32'(busy), 32'(1));
                chk("collect_no_ferr", 32'(frame_err), 32'(0));
            end
            if (k > 0) chk("collect_no_valid", 32'(m_valid), 32'(0));
            x_valid = 1'b1;
            x_in    = frame_w[k];
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_in    = '0;
    endtask

    // mode 0: ready=1, 1: 1,0,0 pattern, 2: random ready, 3: stalled overrun burst, 4: reset at word 7
    task automatic drain(input int mode);
        int   n = 0;
        int   c = 0;
        logic rdy;
        while (n < 16 && c < 200) begin
            if (c > 0) @(negedge clk);
            if (mode == 4 && n == 7) begin
                reset = 1'b1;
                #1;
                chk("reset_mid_valid", 32'(m_valid), 32'(0));
                chk("reset_mid_busy", 32'(busy), 32'(0));
                chk("reset_mid_idx", 32'(m_idx), 32'(0));
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            chk(c == 0 ? "first_valid_latency" : "drain_valid", 32'(m_valid), 32'(1));
            if (m_valid) begin
                chk("drain_idx", 32'(m_idx), 32'(n));
                chk("drain_data", m_data, exp_word(n));
                chk("drain_int", 32'(m_int), 32'(exp_round(exp_word(n))));
                chk("drain_last", 32'(m_last), 32'(n == 15));
                chk("drain_busy", 32'(busy), 32'(1));
                cap_int[n] = m_int;
            end
            case (mode)
                1:       rdy = (c % 3 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                3: begin
                    rdy     = (c >= 4);
                    x_valid = (c < 4);
                    x_in    = $urandom;
                    if (c == 4) chk("overrun_set", 32'(overrun), 32'(1));
                end
                default: rdy = 1'b1;
            endcase
            m_ready = rdy;
            if (m_valid && rdy) n++;
            c++;
        end
        chk("drain_count", 32'(n), 32'(16));
        @(negedge clk);
        m_ready = 1'b0;
        x_valid = 1'b0;
        chk("post_drain_valid", 32'(m_valid), 32'(0));
        chk("post_drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        m_ready = 1'b0;
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", m_data, 32'(0));
        chk("rst_m_idx", 32'(m_idx), 32'(0));
        chk("rst_m_int", 32'(m_int), 32'(0));
        chk("rst_m_last", 32'(m_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Ramp burst, full-rate drain
        for (int k = 0; k < 16; k++) frame_w[k] = 32'(k) << 16;
        send_frame(16);
        drain(0);
        chk("ramp_idx4_int", 32'(cap_int[4]), 32'(1));
        chk("ramp_idx1_int", 32'(cap_int[1]), 32'(4));

        // Random data, ready 1,0,0 pattern
        fill_random();
        send_frame(16);
        drain(1);

        // Rounding and saturation corners on natural indices 0..4
        fill_random();
        frame_w[0]  = 32'h0001_8000;
        frame_w[4]  = 32'hFFFF_8000;
        frame_w[8]  = 32'hFFFE_7FFF;
        frame_w[12] = 32'h7FFF_FFFF;
        frame_w[1]  = 32'h8000_0000;
        send_frame(16);
        drain(0);
        chk("round_up_half", 32'(cap_int[0]), 32'(16'd2));
        chk("round_neg_half", 32'(cap_int[1]), 32'(16'd0));
        chk("round_neg", 32'(cap_int[2]), 32'(16'hFFFE));
        chk("sat_pos", 32'(cap_int[3]), 32'(16'h7FFF));
        chk("sat_neg", 32'(cap_int[4]), 32'(16'h8000));

        // Short burst of 9 words, then a good random frame with random ready
        fill_random();
        send_frame(9);
        @(negedge clk);
        chk("ferr_pulse", 32'(frame_err), 32'(1));
        chk("ferr_busy", 32'(busy), 32'(0));
        chk("ferr_no_valid", 32'(m_valid), 32'(0));
        @(negedge clk);
        chk("ferr_single", 32'(frame_err), 32'(0));
        chk("ferr_still_no_valid", 32'(m_valid), 32'(0));
        fill_random();
        send_frame(16);
        drain(2);

        // Overrun while stalled in drain; sticky until next frame start
        fill_random();
        send_frame(16);
        drain(3);
        chk("overrun_sticky", 32'(overrun), 32'(1));
        fill_random();
        send_frame(16);
        drain(0);

        // Reset during drain, then a clean frame
        fill_random();
        send_frame(16);
        drain(4);
        chk("after_reset_overrun", 32'(overrun), 32'(0));
        fill_random();
        send_frame(16);
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
